// File: rtl/mealy_arb_pkg.sv
// Shared types and constants for the two-requester arbiter that time-shares one
// mealy machine.
package mealy_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  // Symbol presented to the machine, packed as {a, b}.
  typedef logic [1:0] sym_t;

  // Per-symbol machine result.
  typedef logic [1:0] y_t;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StOwn,
    StDrain
  } arb_state_e;

endpackage

// File: rtl/mealy_arbiter_rr_pick2.sv
// Combinational two-way round-robin select. On a tie the requester that did
// not own the machine last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic idx
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      idx = ~last;
    end else begin
      idx = req1;
    end
  end

endmodule

// File: rtl/mealy_arbiter.sv
// Round-robin owner arbiter for a single shared mealy machine. Each tenure
// opens with a one-cycle machine reset and closes with a one-cycle drain.
module mealy_arbiter
  import mealy_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [1:0] sym0,
  input  logic [1:0] sym1,
  input  logic       sym0_valid,
  input  logic       sym1_valid,
  output logic       sym0_ready,
  output logic       sym1_ready,
  input  logic       done0,
  input  logic       done1,
  output logic [1:0] y_out,
  output logic       y_valid,
  output logic       y_owner,
  output logic       m_a,
  output logic       m_b,
  output logic       m_rst,
  input  logic [1:0] m_y
);

  logic [NUM_REQ-1:0] req_v;
  logic [NUM_REQ-1:0] valid_v;
  logic [NUM_REQ-1:0] done_v;
  sym_t               sym_v [NUM_REQ];

  arb_state_e         state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic               m_a_q, m_a_d;
  logic               m_b_q, m_b_d;
  logic               m_rst_q, m_rst_d;
  logic               pend_q, pend_d;
  y_t                 y_out_q, y_out_d;
  logic               y_valid_q, y_valid_d;
  logic               y_owner_q, y_owner_d;

  logic               pick_any;
  logic               pick_idx;
  logic               hs;
  logic               own_release;
  sym_t               own_sym;

  assign req_v    = {req1, req0};
  assign valid_v  = {sym1_valid, sym0_valid};
  assign done_v   = {done1, done0};
  assign sym_v[0] = sym0;
  assign sym_v[1] = sym1;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;

    // Non-owner valid/done never reach these terms.
    own_sym     = sym_v[owner_q];
    hs          = (state_q == StOwn) && valid_v[owner_q] && rdy_q[owner_q];
    own_release = done_v[owner_q] || !req_v[owner_q];

    case (state_q)
      StIdle: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = StFlush;
        end
      end
      StFlush: state_d = StOwn;
      StOwn: begin
        if (own_release) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    // Grant only once OWN is settled, so ready never appears during FLUSH and
    // drops on the release edge itself.
    if ((state_q == StOwn) && (state_d == StOwn)) begin
      gnt_d[owner_q] = 1'b1;
    end
    rdy_d = gnt_d;

    m_rst_d = (state_d == StFlush);
    m_a_d   = hs ? own_sym[1] : 1'b0;
    m_b_d   = hs ? own_sym[0] : 1'b0;
    pend_d  = hs;

    // The machine output for a symbol is valid the cycle after its handshake.
    y_valid_d = pend_q;
    y_out_d   = pend_q ? m_y : y_out_q;
    y_owner_d = pend_q ? owner_q : y_owner_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      gnt_q     <= '0;
      rdy_q     <= '0;
      m_a_q     <= 1'b0;
      m_b_q     <= 1'b0;
      m_rst_q   <= 1'b1;
      pend_q    <= 1'b0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      y_owner_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      rdy_q     <= rdy_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      m_rst_q   <= m_rst_d;
      pend_q    <= pend_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      y_owner_q <= y_owner_d;
    end
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign sym0_ready = rdy_q[0];
  assign sym1_ready = rdy_q[1];
  assign m_a        = m_a_q;
  assign m_b        = m_b_q;
  assign m_rst      = m_rst_q;
  assign y_out      = y_out_q;
  assign y_valid    = y_valid_q;
  assign y_owner    = y_owner_q;

endmodule

// File: tb/tb_mealy_arbiter.sv
// Randomised self-checking bench for mealy_arbiter with a behavioural mealy
// machine attached to the m_* ports and a tenure-level reference model.
module tb_mealy_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic [1:0] sym0, sym1;
  logic       sym0_valid, sym1_valid;
  logic       sym0_ready, sym1_ready;
  logic       done0, done1;
  logic [1:0] y_out;
  logic       y_valid;
  logic       y_owner;
  logic       m_a, m_b, m_rst;
  logic [1:0] m_y;

  int         n_chk  = 0;
  int         n_fail = 0;
  bit         exp_last;
  logic [1:0] seq_sym [8];
  bit         seq_gap [8];
  logic [1:0] mach_q;

  always #5 clk = ~clk;

  mealy_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .sym0       (sym0),
    .sym1       (sym1),
    .sym0_valid (sym0_valid),
    .sym1_valid (sym1_valid),
    .sym0_ready (sym0_ready),
    .sym1_ready (sym1_ready),
    .done0      (done0),
    .done1      (done1),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .y_owner    (y_owner),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_rst      (m_rst),
    .m_y        (m_y)
  );

  // Stand-in mealy machine: 2-bit state, synchronous active-high reset.
  function automatic logic [1:0] mach_nx(input logic [1:0] st, input logic [1:0] s);
    return st + s + 2'd1;
  endfunction

  function automatic logic [1:0] mach_out(input logic [1:0] st, input logic [1:0] s);
    return st ^ {s[0], s[1]};
  endfunction

  always_ff @(posedge clk) begin
    if (m_rst) mach_q <= 2'd0;
    else       mach_q <= mach_nx(mach_q, {m_a, m_b});
  end
  assign m_y = mach_out(mach_q, {m_a, m_b});

  function automatic bit pick(input bit r0, input bit r1, input bit lst);
    if (r0 && r1) return !lst;
    return r1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit idx, input logic [1:0] s, input bit v, input bit d);
    if (idx) begin
      sym1 = s; sym1_valid = v; done1 = d;
    end else begin
      sym0 = s; sym0_valid = v; done0 = d;
    end
  endtask

  task automatic set_req(input bit idx, input bit v);
    if (idx) req1 = v;
    else     req0 = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 0; req1 = 0;
    drive(0, 2'b00, 0, 0);
    drive(1, 2'b00, 0, 0);
    tick();
    tick();
    check_eq("rst_gnt", {gnt1, gnt0}, 2'b00);
    check_eq("rst_ready", {sym1_ready, sym0_ready}, 2'b00);
    check_eq("rst_m_ab", {m_a, m_b}, 2'b00);
    check_eq("rst_m_rst", m_rst, 1'b1);
    check_eq("rst_y_out", y_out, 2'b00);
    check_eq("rst_y_valid", y_valid, 1'b0);
    check_eq("rst_y_owner", y_owner, 1'b0);
    rst = 1'b1;
    tick();
    check_eq("rst_rel_m_rst", m_rst, 1'b0);
    exp_last = 1'b1;
  endtask

  // Runs one full tenure. Entry: the next edge is an IDLE edge at which `who`
  // wins. Exit: just after the DRAIN edge, so the following edge is IDLE again.
  task automatic tenure(input bit who, input int nsym, input bit use_done,
                        input bit keep_req, input bit noise);
    logic [1:0] mst;
    logic [1:0] psym;
    logic [1:0] want;
    bit         phs;
    bit         gap;
    bit         gap_taken;
    bit         last;
    int         i;
    tick();
    check_eq("flush_m_rst", m_rst, 1'b1);
    check_eq("flush_gnt", {gnt1, gnt0}, 2'b00);
    check_eq("flush_y_valid", y_valid, 1'b0);
    tick();
    check_eq("own0_m_rst", m_rst, 1'b0);
    check_eq("own0_gnt", {gnt1, gnt0}, 2'b00);
    check_eq("own0_m_ab", {m_a, m_b}, 2'b00);
    mst = 2'd0;
    tick();
    mst = mach_nx(mst, 2'b00);
    want = who ? 2'b10 : 2'b01;
    check_eq("grant", {gnt1, gnt0}, want);
    check_eq("ready", {sym1_ready, sym0_ready}, want);
    phs = 0; psym = 2'b00; gap_taken = 0; i = 0;
    while (i < nsym) begin
      gap  = seq_gap[i] && !gap_taken;
      last = !gap && (i == nsym - 1);
      if (!gap) drive(who, seq_sym[i], 1, 0);
      if (last) begin
        if (use_done) drive(who, seq_sym[i], 1, 1);
        else          set_req(who, 0);
      end
      if (noise) drive(!who, 2'($urandom), 1, 1);
      tick();
      // The machine consumes whatever was loaded at the previous edge.
      if (phs) begin
        check_eq("y_valid", y_valid, 1'b1);
        check_eq("y_out", y_out, mach_out(mst, psym));
        check_eq("y_owner", y_owner, who);
        mst = mach_nx(mst, psym);
      end else begin
        check_eq("y_quiet", y_valid, 1'b0);
        mst = mach_nx(mst, 2'b00);
      end
      check_eq("m_ab", {m_a, m_b}, gap ? 2'b00 : seq_sym[i]);
      if (noise) check_eq("nonowner_ready", who ? sym0_ready : sym1_ready, 1'b0);
      drive(who, 2'b00, 0, 0);
      if (noise) drive(!who, 2'b00, 0, 0);
      if (last) begin
        check_eq("drain_gnt", {gnt1, gnt0}, 2'b00);
        check_eq("drain_ready", {sym1_ready, sym0_ready}, 2'b00);
      end else begin
        check_eq("hold_gnt", {gnt1, gnt0}, want);
      end
      if (gap) begin
        phs = 0; gap_taken = 1;
      end else begin
        phs = 1; psym = seq_sym[i]; gap_taken = 0; i++;
      end
    end
    if (use_done && !keep_req) set_req(who, 0);
    tick();
    check_eq("last_y_valid", y_valid, 1'b1);
    check_eq("last_y_out", y_out, mach_out(mst, psym));
    check_eq("last_y_owner", y_owner, who);
    check_eq("idle_gnt", {gnt1, gnt0}, 2'b00);
    check_eq("idle_m_ab", {m_a, m_b}, 2'b00);
    exp_last = who;
  endtask

  task automatic load_random(input int n, input int gap_pct);
    for (int k = 0; k < 8; k++) begin
      seq_sym[k] = 2'($urandom);
      seq_gap[k] = (k > 0) && ($urandom_range(99) < 32'(gap_pct));
    end
    if (n < 1) seq_gap[0] = 0;
  endtask

  initial begin
    bit who;
    do_reset();

    // Single owner, fixed sequence 00,01,00,10,11 streamed back-to-back.
    seq_sym[0] = 2'b00; seq_sym[1] = 2'b01; seq_sym[2] = 2'b00;
    seq_sym[3] = 2'b10; seq_sym[4] = 2'b11;
    for (int k = 0; k < 8; k++) seq_gap[k] = 0;
    req0 = 1;
    tenure(pick(1, 0, exp_last), 5, 1, 0, 0);

    // Tie after reset: 0 first, then 1 after done0.
    do_reset();
    req0 = 1; req1 = 1;
    load_random(2, 0);
    who = pick(req0, req1, exp_last);
    tenure(who, 2, 1, 0, 0);
    load_random(3, 0);
    tenure(pick(req0, req1, exp_last), 3, 1, 0, 0);

    // Fairness: both hold requests, each releases after 3 symbols.
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      load_random(3, 0);
      tenure(pick(req0, req1, exp_last), 3, 1, 1, 0);
    end
    req0 = 0; req1 = 0;
    tick();

    // Gap and last-cycle release by owner 1.
    seq_sym[0] = 2'b01; seq_sym[1] = 2'b11;
    seq_gap[0] = 0;     seq_gap[1] = 1;
    req1 = 1;
    tenure(pick(0, 1, exp_last), 2, 1, 0, 0);

    // Non-owner noise while requester 0 owns.
    load_random(5, 20);
    req0 = 1;
    tenure(pick(1, 0, exp_last), 5, 1, 0, 1);

    // Reset mid-stream with one symbol in flight.
    req0 = 1;
    tick(); tick(); tick();
    check_eq("mid_gnt", {gnt1, gnt0}, 2'b01);
    drive(0, 2'b10, 1, 0);
    tick();
    check_eq("mid_m_ab", {m_a, m_b}, 2'b10);
    drive(0, 2'b00, 0, 0);
    rst = 0;
    tick();
    check_eq("mid_rst_gnt", {gnt1, gnt0}, 2'b00);
    check_eq("mid_rst_ready", {sym1_ready, sym0_ready}, 2'b00);
    check_eq("mid_rst_y_valid", y_valid, 1'b0);
    check_eq("mid_rst_m_rst", m_rst, 1'b1);
    rst = 1; req0 = 0;
    tick();
    check_eq("mid_rel_m_rst", m_rst, 1'b0);
    check_eq("mid_rel_y_valid", y_valid, 1'b0);
    exp_last = 1;
    // A tie now must go to 0 with normal IDLE timing.
    req0 = 1; req1 = 1;
    load_random(2, 0);
    tenure(pick(req0, req1, exp_last), 2, 0, 0, 0);
    req1 = 0;
    tick();

    // Random single-requester tenures.
    for (int k = 0; k < 24; k++) begin
      int n;
      bit ud;
      bit r;
      n  = $urandom_range(8, 1);
      ud = 1'($urandom);
      r  = 1'($urandom);
      load_random(n, 30);
      set_req(r, 1);
      tenure(pick(!r, r, exp_last), n, ud, 0, 1'($urandom));
      if ($urandom_range(3) == 0) begin
        tick();
        check_eq("gap_idle_gnt", {gnt1, gnt0}, 2'b00);
        check_eq("gap_idle_y", y_valid, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_arbiter.md
# mealy_arbiter

Two-requester round-robin arbiter that shares one `mealy` instance (inputs `a`, `b`, `rst`; 2-bit output `y`) between two symbol streams. The arbiter grants ownership, resets the machine so every owner starts from its reset state, and streams the owner's `{a,b}` symbols into the machine. It returns each per-symbol `y` tagged with the owner. It sits between the stimulus sources and the single `mealy` instance, and is the only driver of that machine's inputs.

## Interface
- No parameters; symbol width is fixed at 2 (`{a,b}`) and result width at 2.

- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req0`, `req1`  in  1  request ownership; held high until released
- `gnt0`, `gnt1`  out  1  ownership granted, one-hot or zero
- `sym0`, `sym1`  in  2  symbol `{a,b}` from requester
- `sym0_valid`, `sym1_valid`  in  1  symbol present
- `sym0_ready`, `sym1_ready`  out  1  arbiter accepts symbol this cycle
- `done0`, `done1`  in  1  owner releases after this cycle
- `y_out`  out  2  registered machine output for an accepted symbol
- `y_valid`  out  1  `y_out` is valid this cycle, single-cycle pulse per symbol
- `y_owner`  out  1  requester index that `y_out` belongs to
- `m_a`, `m_b`  out  1  to machine `a`, `b`, registered
- `m_rst`  out  1  to machine `rst`, active-high, registered
- `m_y`  in  2  from machine `y`, combinational Mealy output

## Operation
- States: IDLE, FLUSH, OWN, DRAIN. A `last` pointer stores the index of the previous owner.
- IDLE:
  - If only one `reqN` is high, that requester wins.
  - If both are high, the requester with index ≠ `last` wins.
  - The winner is registered as `owner` and the state goes to FLUSH.
- FLUSH:
  - Lasts one cycle with `m_rst`=1 and `m_a`=`m_b`=0, then goes to OWN.
  - A `req` drop during FLUSH is ignored.
- OWN:
  - `gnt[owner]`=1 and `sym_ready[owner]`=1. The non-owner's `gnt` and `ready` stay 0.
  - A handshake (`valid`&`ready`) loads `m_a`/`m_b` from `sym[owner]`.
  - A cycle with no handshake loads `m_a`=`m_b`=0. This is a real `{0,0}` symbol to the machine but produces no `y_valid`, so owners needing exact sequences must stream back-to-back.
  - Release is `done[owner]`, or `req[owner]` low. A symbol handshaked in the release cycle is still accepted.
  - On release the state goes to DRAIN.
- DRAIN:
  - Lasts one cycle, with `gnt`=0, `ready`=0 and `m_a`=`m_b`=0.
  - Captures the final pending `y`, sets `last`←`owner`, then goes to IDLE.
- A `doneN` or `symN_valid` from the non-owner is ignored.

## Timing
- Reset (`rst`=0 at an edge) gives:
  - state IDLE and `last`=1, so requester 0 wins the first tie;
  - `gnt`=0, `ready`=0, `m_a`=`m_b`=0, `m_rst`=1;
  - `y_out`=0, `y_valid`=0, `y_owner`=0, and the pending flag cleared.
- First edge after reset release: `m_rst`=0.
- Reset mid-operation aborts immediately. No `y_valid` is emitted for in-flight symbols.
- Request to grant: `req` sampled high at edge t in IDLE → `m_rst` high in cycle t..t+1 → `gnt` high from edge t+2.
- Symbol to result:
  - A handshake at edge e drives `m_a`/`m_b` from edge e.
  - `m_y` is sampled into `y_out` at edge e+1, with `y_valid`=1 and `y_owner`=`owner`.
  - The machine advances its state at that same edge e+1.
  - Throughput is 1 symbol per cycle.
- Release to re-arbitration: release at edge r → DRAIN cycle → IDLE at r+2, so the earliest next `gnt` is at r+4.
- Outputs `gnt`, `ready`, `m_*` and `y_*` are all registered. `ready` depends only on state and `owner`, never on `valid`.

## Structure
- Package `mealy_arb_pkg` holds:
  - the state enum (IDLE, FLUSH, OWN, DRAIN);
  - the `sym_t` type (2-bit `{a,b}`);
  - the `y_t` type (2-bit);
  - the constant `NUM_REQ`=2.
- Sub-module `rr_pick2`: combinational 2-way round-robin select from (`req0`, `req1`, `last`) → (`any`, `idx`).
- The top level instantiates `rr_pick2` only. The `mealy` instance lives in the parent and is connected through the `m_*` ports.

## Test plan
- Reset and single owner:
  - Stimulus: `rst`=0 for 2 cycles, then `req0`=1.
  - Required: `m_rst`=1 through reset and FLUSH; `gnt0`=1 two edges after `req0`.
  - Required: the streamed symbols 00, 01, 00, 10, 11 produce five `y_valid` pulses with `y_owner`=0.
  - Required: each `y_out` equals the reference `mealy` model output for that symbol.
- Tie break:
  - Stimulus: `req0`=`req1`=1 in IDLE after reset.
  - Required: `gnt0` first; after `done0`, `gnt1` follows with a FLUSH pulse on `m_rst` between the two grants.
- Round-robin fairness:
  - Stimulus: both requesters hold `req` high and each releases after 3 symbols.
  - Required: grants alternate 0,1,0,1 and no requester is granted twice in a row.
- Gap and last-cycle release:
  - Stimulus: owner 1 sends 01, drops `valid` for 1 cycle, then sends 11 together with `done1` in the same cycle.
  - Required: `m_a`/`m_b` are 0/0 in the gap cycle.
  - Required: exactly two `y_valid` pulses; the second appears in the DRAIN-following cycle.
- Reset mid-stream:
  - Stimulus: `rst`=0 during OWN with one symbol in flight.
  - Required: next cycle `gnt`=0, `y_valid`=0, `m_rst`=1, and the state is IDLE.
- Non-owner noise:
  - Stimulus: during owner-0 OWN, `sym1_valid`=1 and `done1`=1.
  - Required: `sym1_ready`=0, no effect on `m_a`/`m_b`, and owner 0's grant is unaffected.
